// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, in-order variable-latency IMEM requests, DEPTH-entry PC-tagged prefetch queue.
// Latency: >=2 cycles from request acceptance to instr_valid (1 cycle with optional FETCH_BYPASS_EN forwarding).
// Backpressure: requests are credit-limited (outstanding + occupancy < DEPTH); decode stalls via instr_ready.
module fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = 2,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  fetch_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   squash_q, squash_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_d [DEPTH];

    logic accept;
    logic resp_fire;
    logic resp_live;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        imem_req  = ~rst & ~halt & ~redirect &
                    (({1'b0, outstanding_q} + {1'b0, count_q}) < (CNT_W + 1)'(DEPTH));
        accept    = imem_req & imem_ready;
        // A response with nothing outstanding is a leftover from before reset.
        resp_fire = imem_rvalid & (outstanding_q != '0);
        resp_live = resp_fire & (squash_q == '0);
`ifdef FETCH_BYPASS_EN
        bypass    = resp_live & ~redirect & instr_ready & (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        push      = resp_live & ~redirect & ~bypass;
        pop       = (count_q != '0) & instr_ready & ~redirect;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(resp_fire);
        squash_d      = squash_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Every in-flight request is stale now, including ones already marked for squash.
            squash_d   = outstanding_q - CNT_W'(resp_fire);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + INC;
            end
            if (resp_fire && (squash_q != '0)) begin
                squash_d = squash_q - CNT_W'(1);
            end
            if (resp_live) begin
                resp_pc_d = resp_pc_q + INC;
            end
            if (push) begin
                instr_mem_d[wr_ptr_q] = imem_rdata;
                pc_mem_d[wr_ptr_q]    = resp_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= ADDR_W'(RESET_PC);
            resp_pc_q     <= ADDR_W'(RESET_PC);
            outstanding_q <= '0;
            squash_q      <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

    always_comb begin
        imem_addr = fetch_pc_q;
        fetch_pc  = fetch_pc_q;
        halted    = halt & (outstanding_q == '0);
`ifdef FETCH_BYPASS_EN
        instr_valid = (count_q != '0) | bypass;
        instr       = bypass ? imem_rdata : instr_mem_q[rd_ptr_q];
        instr_pc    = bypass ? resp_pc_q  : pc_mem_q[rd_ptr_q];
`else
        instr_valid = (count_q != '0);
        instr       = instr_mem_q[rd_ptr_q];
        instr_pc    = pc_mem_q[rd_ptr_q];
`endif
    end

endmodule
